// File: rtl/vgasync2.sv
// vgasync2 - parametrised VGA timing generator for the vdp99 video path.
// Produces sync, active-video, border and pixel coordinates from one pixel
// clock, with runtime graphics/text horizontal layouts switched on frame
// boundaries and an optional output delay of DLY extra stages.
// Build option: define VGASYNC2_IRQ_EN to add the frame interrupt
// (irq_ack input, irq output); without it no interrupt logic exists.
module vgasync2 #(
    parameter int HVID   = 512,
    parameter int HRB    = 64,
    parameter int HLB    = 64,
    parameter int HVID_T = 480,
    parameter int HRB_T  = 80,
    parameter int HLB_T  = 80,
    parameter int HFP    = 16,
    parameter int HS     = 96,
    parameter int HBP    = 48,
    parameter int VVID   = 384,
    parameter int VBB    = 48,
    parameter int VFP    = 10,
    parameter int VS     = 2,
    parameter int VBP    = 33,
    parameter int VTB    = 48,
    parameter int HW     = 10,
    parameter int VW     = 10,
    parameter bit HSPOL  = 1'b0,
    parameter bit VSPOL  = 1'b0,
    parameter int DLY    = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          text_mode,
`ifdef VGASYNC2_IRQ_EN
    input  logic          irq_ack,
    output logic          irq,
`endif
    output logic          hsync,
    output logic          vsync,
    output logic          vid_active,
    output logic          border,
    output logic [HW-1:0] col,
    output logic [VW-1:0] row,
    output logic          frame_start
);

    localparam int HTOT   = HVID + HRB + HFP + HS + HBP + HLB;
    localparam int HTOT_T = HVID_T + HRB_T + HFP + HS + HBP + HLB_T;
    localparam int VTOT   = VVID + VBB + VFP + VS + VBP + VTB;

    // Both layouts must share one line length so the vertical timing and
    // the sync position in time stay independent of the selected mode.
    if (HTOT_T != HTOT) begin : g_bad_text_layout
        $error("vgasync2: text layout line length differs from graphics");
    end
    if (DLY < 0 || DLY > 3) begin : g_bad_dly
        $error("vgasync2: DLY must be in 0..3");
    end

    localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);

    // Horizontal region boundaries, graphics layout
    localparam logic [HW-1:0] G_ACT_END = HW'(HVID);
    localparam logic [HW-1:0] G_RB_END  = HW'(HVID + HRB);
    localparam logic [HW-1:0] G_HS_BEG  = HW'(HVID + HRB + HFP);
    localparam logic [HW-1:0] G_HS_END  = HW'(HVID + HRB + HFP + HS);
    localparam logic [HW-1:0] G_LB_BEG  = HW'(HTOT - HLB);
    // Horizontal region boundaries, text layout
    localparam logic [HW-1:0] T_ACT_END = HW'(HVID_T);
    localparam logic [HW-1:0] T_RB_END  = HW'(HVID_T + HRB_T);
    localparam logic [HW-1:0] T_HS_BEG  = HW'(HVID_T + HRB_T + HFP);
    localparam logic [HW-1:0] T_HS_END  = HW'(HVID_T + HRB_T + HFP + HS);
    localparam logic [HW-1:0] T_LB_BEG  = HW'(HTOT - HLB_T);
    // Vertical region boundaries
    localparam logic [VW-1:0] V_ACT_END = VW'(VVID);
    localparam logic [VW-1:0] V_BB_END  = VW'(VVID + VBB);
    localparam logic [VW-1:0] V_VS_BEG  = VW'(VVID + VBB + VFP);
    localparam logic [VW-1:0] V_VS_END  = VW'(VVID + VBB + VFP + VS);
    localparam logic [VW-1:0] V_TB_BEG  = VW'(VTOT - VTB);

    // One pipeline word: every output that must stay mutually aligned.
    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          vid_active;
        logic          border;
        logic          frame_start;
`ifdef VGASYNC2_IRQ_EN
        logic          irq_set;
`endif
        logic [HW-1:0] col;
        logic [VW-1:0] row;
    } flags_t;

    // Reset / idle value of a pipeline word: syncs inactive, all else 0.
    function automatic flags_t idle_flags();
        flags_t f;
        f       = '0;
        f.hsync = ~HSPOL;
        f.vsync = ~VSPOL;
        return f;
    endfunction

    logic          run;     // low for the single hold cycle after reset
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          mode_r;  // 1 = text layout for the current frame

    logic [HW-1:0] h_act_end, h_rb_end, h_hs_beg, h_hs_end, h_lb_beg;
    logic          h_active, h_border, h_sync;
    logic          v_active, v_border, v_sync;
    logic          vid;
    flags_t        nxt;
    flags_t        stage_in [0:DLY];
    flags_t        pipe     [0:DLY];

    // Position counters and frame-boundary layout latch
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run    <= 1'b0;
            hpos   <= '0;
            vpos   <= '0;
            mode_r <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (hpos == H_LAST) begin
                    hpos <= '0;
                    if (vpos == V_LAST) begin
                        vpos   <= '0;
                        mode_r <= text_mode;
                    end else begin
                        vpos <= vpos + 1'b1;
                    end
                end else begin
                    hpos <= hpos + 1'b1;
                end
            end
        end
    end

    // Decode the current counter position into the next pipeline word
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        h_act_end = mode_r ? T_ACT_END : G_ACT_END;
        h_rb_end  = mode_r ? T_RB_END  : G_RB_END;
        h_hs_beg  = mode_r ? T_HS_BEG  : G_HS_BEG;
        h_hs_end  = mode_r ? T_HS_END  : G_HS_END;
        h_lb_beg  = mode_r ? T_LB_BEG  : G_LB_BEG;

        h_active = (hpos < h_act_end);
        h_border = ((hpos >= h_act_end) && (hpos < h_rb_end)) || (hpos >= h_lb_beg);
        h_sync   = (hpos >= h_hs_beg) && (hpos < h_hs_end);
        v_active = (vpos < V_ACT_END);
        v_border = ((vpos >= V_ACT_END) && (vpos < V_BB_END)) || (vpos >= V_TB_BEG);
        v_sync   = (vpos >= V_VS_BEG) && (vpos < V_VS_END);
        vid      = h_active & v_active;

        nxt = idle_flags();
        if (run) begin
            nxt.hsync       = h_sync ? HSPOL : ~HSPOL;
            nxt.vsync       = v_sync ? VSPOL : ~VSPOL;
            nxt.vid_active  = vid;
            nxt.border      = ~vid & ((h_border & (v_active | v_border)) | (h_active & v_border));
            nxt.frame_start = (hpos == '0) && (vpos == '0);
`ifdef VGASYNC2_IRQ_EN
            nxt.irq_set     = (hpos == '0) && (vpos == V_ACT_END);
`endif
            nxt.col         = vid ? hpos : '0;
            nxt.row         = vid ? vpos : '0;
        end
    end

    // Input of each pipeline stage: decoded word, then the previous stage
    always_comb begin
        stage_in[0] = nxt;
        for (int i = 1; i <= DLY; i++) begin
            stage_in[i] = pipe[i-1];
        end
    end

    // Output pipeline, 1+DLY registers deep
    // NOTE: the delay stages are reset explicitly so no stale flag or sync
    // pulse can leak out during the first DLY clocks after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= DLY; i++) begin
            pipe[i] <= (!reset) ? idle_flags() : stage_in[i];
        end
    end

`ifdef VGASYNC2_IRQ_EN
    // Frame interrupt, set at the last stage so it aligns with the outputs;
    // a set on the same clock as an acknowledge takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (stage_in[DLY].irq_set) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

    assign hsync       = pipe[DLY].hsync;
    assign vsync       = pipe[DLY].vsync;
    assign vid_active  = pipe[DLY].vid_active;
    assign border      = pipe[DLY].border;
    assign frame_start = pipe[DLY].frame_start;
    assign col         = pipe[DLY].col;
    assign row         = pipe[DLY].row;

endmodule

// File: tb/tb_vgasync2.sv
// tb_vgasync2 - directed bench for vgasync2 with the small test timing
// (HTOT=18, VTOT=16). Two instances run side by side: DLY=0 and DLY=2.
// Interrupt checks are compiled only when VGASYNC2_IRQ_EN is defined.
module tb_vgasync2;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       vid_active;
        logic       border;
        logic       frame_start;
        logic [9:0] col;
        logic [9:0] row;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       text_mode;
`ifdef VGASYNC2_IRQ_EN
    logic       irq_ack;
    logic       irq0, irq2;
`endif
    logic       hsync0, vsync0, vid0, border0, fs0;
    logic [9:0] col0, row0;
    logic       hsync2, vsync2, vid2, border2, fs2;
    logic [9:0] col2, row2;

    int n_checks = 0;
    int n_fail   = 0;

    // Horizontal segment table: active, right border, front porch, sync,
    // back porch, left border.
    int g_len[6]   = '{5, 2, 2, 3, 4, 2};
    int t_len[6]   = '{3, 3, 2, 3, 4, 3};
    bit seg_vid[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit seg_bd[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit seg_hs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    vgasync2 #(
        .HVID(5), .HRB(2), .HLB(2), .HVID_T(3), .HRB_T(3), .HLB_T(3),
        .HFP(2), .HS(3), .HBP(4), .VVID(3), .VBB(2), .VFP(4), .VS(2),
        .VBP(3), .VTB(2), .DLY(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .text_mode(text_mode),
`ifdef VGASYNC2_IRQ_EN
        .irq_ack(irq_ack), .irq(irq0),
`endif
        .hsync(hsync0), .vsync(vsync0), .vid_active(vid0), .border(border0),
        .col(col0), .row(row0), .frame_start(fs0)
    );

    vgasync2 #(
        .HVID(5), .HRB(2), .HLB(2), .HVID_T(3), .HRB_T(3), .HLB_T(3),
        .HFP(2), .HS(3), .HBP(4), .VVID(3), .VBB(2), .VFP(4), .VS(2),
        .VBP(3), .VTB(2), .DLY(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .text_mode(text_mode),
`ifdef VGASYNC2_IRQ_EN
        .irq_ack(irq_ack), .irq(irq2),
`endif
        .hsync(hsync2), .vsync(vsync2), .vid_active(vid2), .border(border2),
        .col(col2), .row(row2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 2) o = '{hsync2, vsync2, vid2, border2, fs2, col2, row2};
        else          o = '{hsync0, vsync0, vid0, border0, fs0, col0, row0};
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.hsync = 1'b1;
        o.vsync = 1'b1;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input string name, input int sel, input obs_t got, input obs_t exp);
        $display("FAIL %s dut%0d: got hs=%b vs=%b vid=%b bd=%b fs=%b col=%0d row=%0d, want hs=%b vs=%b vid=%b bd=%b fs=%b col=%0d row=%0d",
                 name, sel, got.hsync, got.vsync, got.vid_active, got.border, got.frame_start, got.col, got.row,
                 exp.hsync, exp.vsync, exp.vid_active, exp.border, exp.frame_start, exp.col, exp.row);
    endtask

    task automatic check_obs(input string name, input int sel, input obs_t exp);
        obs_t got;
        got = get_obs(sel);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            report(name, sel, got, exp);
        end
    endtask

    // Step until the selected instance shows frame_start, bounded.
    task automatic wait_fs(input int sel, input string name);
        int   n;
        bit   hit;
        obs_t o;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 400) begin
            step();
            n++;
            o = get_obs(sel);
            hit = (o.frame_start === 1'b1);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: frame_start of dut%0d not seen within %0d clocks", name, sel, n);
        end
    endtask

    // Check one full 18-clock line starting at its hpos=0 output cycle.
    task automatic check_line(input int sel, input bit text, input int row_e, input string name);
        int   h;
        int   len;
        obs_t exp;
        h = 0;
        for (int s = 0; s < 6; s++) begin
            len = text ? t_len[s] : g_len[s];
            for (int k = 0; k < len; k++) begin
                exp             = '0;
                exp.hsync       = seg_hs[s];
                exp.vsync       = 1'b1;
                exp.vid_active  = seg_vid[s];
                exp.border      = seg_bd[s];
                exp.frame_start = (row_e == 0 && h == 0);
                exp.col         = seg_vid[s] ? 10'(h) : 10'd0;
                exp.row         = seg_vid[s] ? 10'(row_e) : 10'd0;
                check_obs(name, sel, exp);
                step();
                h++;
            end
        end
    endtask

    // Count clocks from reset release to the first frame_start of each DUT.
    task automatic measure_release(input string name);
        int first0, first2;
        first0 = 0;
        first2 = 0;
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (fs0 === 1'b1 && first0 == 0) first0 = k;
            if (fs2 === 1'b1 && first2 == 0) first2 = k;
        end
        n_checks++;
        if (first0 != 2) begin
            n_fail++;
            $display("FAIL %s dly0: first frame_start at clock %0d, want 2", name, first0);
        end
        n_checks++;
        if (first2 != 4) begin
            n_fail++;
            $display("FAIL %s dly2: first frame_start at clock %0d, want 4", name, first2);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        text_mode = 1'b0;
`ifdef VGASYNC2_IRQ_EN
        irq_ack   = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            check_obs("reset_idle", 0, idle_obs());
            check_obs("reset_idle", 2, idle_obs());
        end
        measure_release("reset_release");
    endtask

    task automatic test_frame_period();
        int n;
        wait_fs(0, "period_sync");
        n = 0;
        do begin
            step();
            n++;
        end while (fs0 !== 1'b1 && n < 400);
        n_checks++;
        if (n != 288) begin
            n_fail++;
            $display("FAIL frame_period: %0d clocks between frame_start pulses, want 288", n);
        end
    endtask

    task automatic test_graphics_line();
        // Called on the dut0 frame_start cycle.
        check_line(0, 1'b0, 0, "gfx_line");
        wait_fs(2, "gfx_line_sync2");
        check_line(2, 1'b0, 0, "gfx_line");
    endtask

    task automatic test_vsync();
        int n, cnt;
        wait_fs(0, "vsync_sync");
        n = 0;
        while (vsync0 !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 162) begin
            n_fail++;
            $display("FAIL vsync_start: vsync fell %0d clocks after frame_start, want 162", n);
        end
        cnt = 0;
        while (vsync0 === 1'b0 && cnt < 100) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt != 36) begin
            n_fail++;
            $display("FAIL vsync_width: vsync low for %0d clocks, want 36", cnt);
        end
    endtask

    task automatic test_text_mode();
        wait_fs(0, "text_sync");
        for (int k = 0; k < 20; k++) step();
        text_mode = 1'b1;
        for (int k = 0; k < 16; k++) step();
        check_line(0, 1'b0, 2, "text_midframe_keeps_gfx");
        wait_fs(0, "text_sync_next");
        check_line(0, 1'b1, 0, "text_line");
        wait_fs(2, "text_sync2");
        check_line(2, 1'b1, 0, "text_line");
    endtask

`ifdef VGASYNC2_IRQ_EN
    task automatic check_irq(input string name, input int sel, input logic exp);
        logic got;
        got = (sel == 2) ? irq2 : irq0;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: irq=%b, want %b", name, sel, got, exp);
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic test_irq();
        wait_fs(0, "irq_sync");                  // t0: position (0,0)
        pulse_ack();                             // t0+1
        check_irq("irq_cleared", 0, 1'b0);
        check_irq("irq_cleared", 2, 1'b0);
        for (int k = 0; k < 52; k++) step();     // t0+53
        check_irq("irq_before_set", 0, 1'b0);
        step();                                  // t0+54: line 3, hpos 0
        check_irq("irq_set_line3", 0, 1'b1);
        for (int k = 0; k < 10; k++) step();     // t0+64
        check_irq("irq_hold", 0, 1'b1);
        check_irq("irq_hold", 2, 1'b1);
        pulse_ack();                             // t0+65
        check_irq("irq_ack_clears", 0, 1'b0);
        check_irq("irq_ack_clears", 2, 1'b0);
        pulse_ack();                             // t0+66
        check_irq("irq_ack_when_clear", 0, 1'b0);
        for (int k = 0; k < 275; k++) step();    // t1+53
        check_irq("irq_before_set2", 0, 1'b0);
        irq_ack = 1'b1;
        step();                                  // t1+54: set and ack together
        irq_ack = 1'b0;
        check_irq("irq_set_beats_ack", 0, 1'b1);
        check_irq("irq_dly2_not_yet", 2, 1'b0);
        step();                                  // t1+55
        check_irq("irq_dly2_not_yet", 2, 1'b0);
        step();                                  // t1+56
        check_irq("irq_dly2_set", 2, 1'b1);
    endtask
`endif

    task automatic test_reset_midline();
        obs_t exp;
        wait_fs(0, "midline_sync");
        for (int k = 0; k < 7; k++) step();
        reset = 1'b0;
        step();
        check_obs("midline_reset", 0, idle_obs());
        check_obs("midline_reset", 2, idle_obs());
`ifdef VGASYNC2_IRQ_EN
        check_irq("midline_reset_irq", 0, 1'b0);
        check_irq("midline_reset_irq", 2, 1'b0);
`endif
        step();
        reset = 1'b1;
        step();                                  // hold cycle: still idle
        check_obs("release_hold", 0, idle_obs());
        step();                                  // (0,0) appears, graphics layout
        check_line(0, 1'b0, 0, "gfx_after_reset");
        reset = 1'b0;
        step();
        step();
        measure_release("midline_release");
        exp = idle_obs();
        exp.frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_period();
        test_graphics_line();
        test_vsync();
        test_text_mode();
`ifdef VGASYNC2_IRQ_EN
        test_irq();
`endif
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vgasync2.md
# vgasync2

Parametrised second-generation VGA timing generator for the vdp99 video path. It produces horizontal and vertical sync, active-video, border and pixel-coordinate outputs from a single pixel clock. It supports two horizontal layouts, graphics and text, selected at runtime and switched only on frame boundaries. An output delay lets the flags line up with the downstream pattern/colour fetch pipeline, and a frame interrupt flag can be compiled in.

## Interface
- HVID, 512, graphics-mode active pixels per line
- HRB / HLB, 64 / 64, graphics-mode right / left border pixels
- HVID_T, 480, text-mode active pixels per line
- HRB_T / HLB_T, 80 / 80, text-mode right / left border pixels
- HFP / HS / HBP, 16 / 96 / 48, horizontal front porch / sync / back porch
- VVID / VBB / VFP / VS / VBP / VTB, 384 / 48 / 10 / 2 / 33 / 48, vertical active / bottom border / front porch / sync / back porch / top border lines
- HW / VW, 10 / 10, counter widths
- HSPOL / VSPOL, 0 / 0, active sync level (0 = active-low)
- DLY, 0, extra pipeline stages on flag outputs (0..3)
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- text_mode  in  1  layout select; sampled at frame start only
- irq_ack  in  1  one-cycle pulse that clears irq (IRQ build only)
- hsync / vsync  out  1  sync outputs at HSPOL / VSPOL
- vid_active  out  1  pixel is in the active area
- border  out  1  pixel is in a border area (not active, not blanking)
- col  out  HW  active-area column; 0 outside the active area
- row  out  VW  active-area row; 0 outside the active area
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- irq  out  1  frame interrupt flag (IRQ build only)

## Operation
- Horizontal order: active, right border, front porch, sync, back porch, left border. The line length is HTOT = HVID+HRB+HFP+HS+HBP+HLB.
- Text layout: HTOT_T = HVID_T+HRB_T+HFP+HS+HBP+HLB_T. HTOT_T must equal HTOT; a mismatch is a synthesis-time $error.
- Vertical order: active, bottom border, front porch, sync, back porch, top border. Total is VTOT.
- hpos counts 0..HTOT-1 and wraps to 0. vpos increments when hpos wraps and wraps to 0 after VTOT-1.
- Position 0 of each counter is the first active pixel/line.
- mode_r latches text_mode only when hpos==HTOT-1 and vpos==VTOT-1, so it takes effect at the next (0,0). Mid-frame changes to text_mode are ignored until then.
- vid_active = h_active & v_active.
- border is 1 when the pixel is not active but is in a border: a horizontal border with v_active or v_border, or h_active with v_border.
- Porch and sync regions have vid_active=0 and border=0.
- col/row equal hpos/vpos while vid_active, else 0.
- Reset (reset=0 at clk edge):
  - hpos, vpos, col, row → 0; mode_r → 0 (graphics).
  - hsync and vsync → inactive level.
  - vid_active, border, frame_start, irq and all delay-stage registers → 0.
  - Reset mid-frame restarts timing at (0,0) on the next clock.

## Timing
- All outputs are registered. Flags for counter position (h,v) appear 1+DLY clocks after the counters hold (h,v).
- col and row are delayed by the same 1+DLY, so every output is mutually aligned.
- The first clock after reset is released, the counters hold (0,0).
- frame_start is high exactly one clock per frame, aligned with col=0,row=0,vid_active=1.
- hsync is asserted for exactly HS clocks per line. vsync is asserted for exactly VS×HTOT clocks, starting and ending at hpos=0.
- irq sets on the aligned cycle where vpos==VVID and hpos==0 (first bottom-border line) and holds until irq_ack.
  - If set and irq_ack occur in the same cycle, set wins.
  - irq_ack while irq=0 has no effect.

## Configuration
- VGASYNC2_IRQ_EN defined: irq_ack and irq exist with the behaviour above.
- Not defined: neither port exists and no interrupt logic is synthesised. All other behaviour is identical.

## Test plan
Common bench parameters: HVID=5, HRB=2, HFP=2, HS=3, HBP=4, HLB=2, HVID_T=3, HRB_T=3, HLB_T=3, VVID=3, VBB=2, VFP=4, VS=2, VBP=3, VTB=2, DLY=0. This gives HTOT=18 and VTOT=16.
- Reset for 4 clocks, then release → frame_start is high on the 2nd clock after release. hsync and vsync are high (inactive) during reset. The period between frame_start pulses is 288 clocks.
- Graphics line:
  - vid_active runs for 5 clocks with col 0..4, then border for 2.
  - Then blank for 2, hsync low for 3, blank for 4, border for 2.
- text_mode=1 asserted mid-frame → the current frame keeps the 5-pixel layout. The next frame has vid_active for 3 clocks with col 0..2 and a border of 3 on each side.
- vsync is low for exactly 36 consecutive clocks, starting at line 9, hpos 0.
- IRQ build:
  - irq rises at line 3, hpos 0, and stays high.
  - irq_ack pulse 10 clocks later → irq is 0 the next clock.
  - irq_ack on the same clock as the set condition → irq=1.
- DLY=2 → every output shifts 2 clocks later relative to DLY=0 and stays mutually aligned. Repeat with reset asserted mid-line → outputs return to their reset values the next clock.
